// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge with one register stage per direction and an optional no-response watchdog.
// Optional feature macro: WB_TIMEOUT_BRIDGE_TIMEOUT_EN (builds the timeout counter).
module wb_timeout_bridge #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rstn,
    // upstream side, driven by an interconnect slave port
    input  logic [WB_ADDR_WIDTH-1:0]   m_adr,
    input  logic [WB_DATA_WIDTH-1:0]   m_dat_w,
    input  logic [WB_DATA_WIDTH/8-1:0] m_sel,
    input  logic                       m_we,
    input  logic [2:0]                 m_cti,
    input  logic [1:0]                 m_bte,
    input  logic                       m_cyc,
    input  logic                       m_stb,
    output logic [WB_DATA_WIDTH-1:0]   m_dat_r,
    output logic                       m_ack,
    output logic                       m_err,
    // downstream side, driving the peripheral
    output logic [WB_ADDR_WIDTH-1:0]   s_adr,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0] s_sel,
    output logic                       s_we,
    output logic [2:0]                 s_cti,
    output logic [1:0]                 s_bte,
    output logic                       s_cyc,
    output logic                       s_stb,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_r,
    input  logic                       s_ack,
    input  logic                       s_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       err;
    logic [WB_DATA_WIDTH-1:0]   rsp_data;
    logic                       capture;
    logic                       finish;
    logic                       timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_timeout_bridge: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef WB_TIMEOUT_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Counts REQ cycles; holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (capture) begin
            count <= '0;
        end else if (state == REQ && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    assign capture = (state == IDLE) && m_cyc && m_stb;
    assign finish  = (state == REQ) && m_cyc && (s_ack || s_err || timeout);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (m_cyc && m_stb) state_next = REQ;
            REQ: begin
                if (!m_cyc) begin
                    state_next = IDLE;
                end else if (s_err || s_ack || timeout) begin
                    state_next = RSP;
                end
            end
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields stay on the downstream bus after the access completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_adr    <= '0;
            s_dat_w  <= '0;
            s_sel    <= '0;
            s_we     <= 1'b0;
            s_cti    <= '0;
            s_bte    <= '0;
            err      <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (capture) begin
                s_adr   <= m_adr;
                s_dat_w <= m_dat_w;
                s_sel   <= m_sel;
                s_we    <= m_we;
                s_cti   <= m_cti;
                s_bte   <= m_bte;
            end
            if (finish) begin
                // ERR beats ACK; a watchdog expiry with neither returns ERR with zero data.
                err      <= s_err || !s_ack;
                rsp_data <= (s_ack || s_err) ? s_dat_r : '0;
            end
        end
    end

    always_comb begin
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_dat_r = '0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        unique case (state)
            REQ: begin
                s_cyc = 1'b1;
                s_stb = 1'b1;
            end
            RSP: begin
                m_ack   = !err;
                m_err   = err;
                m_dat_r = rsp_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Bench for wb_timeout_bridge: directed vector table, hand sequences and randomized accesses
// checked against a timeline model of when the downstream strobe and upstream response occur.
module tb_wb_timeout_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned T  = 8;
`ifdef WB_TIMEOUT_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] m_adr = '0;
    logic [DW-1:0] m_dat_w = '0;
    logic [SW-1:0] m_sel = '0;
    logic          m_we = 1'b0;
    logic [2:0]    m_cti = '0;
    logic [1:0]    m_bte = '0;
    logic          m_cyc = 1'b0;
    logic          m_stb = 1'b0;
    logic [DW-1:0] m_dat_r;
    logic          m_ack;
    logic          m_err;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w;
    logic [SW-1:0] s_sel;
    logic          s_we;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic          s_cyc;
    logic          s_stb;
    logic [DW-1:0] s_dat_r = '0;
    logic          s_ack = 1'b0;
    logic          s_err = 1'b0;

    wb_timeout_bridge #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .m_adr  (m_adr),
        .m_dat_w(m_dat_w),
        .m_sel  (m_sel),
        .m_we   (m_we),
        .m_cti  (m_cti),
        .m_bte  (m_bte),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_dat_r(m_dat_r),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .s_adr  (s_adr),
        .s_dat_w(s_dat_w),
        .s_sel  (s_sel),
        .s_we   (s_we),
        .s_cti  (s_cti),
        .s_bte  (s_bte),
        .s_cyc  (s_cyc),
        .s_stb  (s_stb),
        .s_dat_r(s_dat_r),
        .s_ack  (s_ack),
        .s_err  (s_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // k: REQ cycle in which the slave responds (0 = silent); abort: REQ cycle with m_cyc dropped (0 = none)
    // exp_rcyc: cycle of the upstream response counted from request cycle 0 (0 = no response)
    typedef struct {
        string         name;
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat_w;
        logic [SW-1:0] sel;
        logic [2:0]    cti;
        logic [1:0]    bte;
        int unsigned   k;
        bit            sack;
        bit            serr;
        logic [DW-1:0] sdat;
        int unsigned   abort;
        int unsigned   limit;
        int unsigned   exp_stb;
        int unsigned   exp_rcyc;
        bit            exp_err;
        logic [DW-1:0] exp_dat;
    } txn_t;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    int unsigned   r_stb;
    int unsigned   r_rcyc;
    bit            r_err;
    logic [DW-1:0] r_dat;
    int unsigned   r_bad;
    int unsigned   r_abs;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    function automatic txn_t mk(input string name, input logic [AW-1:0] adr, input logic we,
                                input logic [DW-1:0] dat_w, input logic [SW-1:0] sel,
                                input int unsigned k, input bit sack, input bit serr,
                                input logic [DW-1:0] sdat, input int unsigned abort,
                                input int unsigned limit, input int unsigned exp_stb,
                                input int unsigned exp_rcyc, input bit exp_err,
                                input logic [DW-1:0] exp_dat);
        txn_t t;
        t.name = name; t.adr = adr; t.we = we; t.dat_w = dat_w; t.sel = sel;
        t.cti = 3'd2; t.bte = 2'd1;
        t.k = k; t.sack = sack; t.serr = serr; t.sdat = sdat;
        t.abort = abort; t.limit = limit;
        t.exp_stb = exp_stb; t.exp_rcyc = exp_rcyc; t.exp_err = exp_err; t.exp_dat = exp_dat;
        return t;
    endfunction

    // Timeline model: the slave answer counts only inside the watchdog window; an abort at or
    // before the response cycle suppresses the response.
    function automatic txn_t model(input txn_t t);
        txn_t        r = t;
        int unsigned resp;
        bit          slave_wins;
        if (t.k != 0 && (!TO_EN || t.k <= T)) resp = t.k;
        else if (TO_EN) resp = T;
        else resp = 0;
        if (t.abort != 0 && (resp == 0 || t.abort <= resp)) begin
            r.exp_stb = t.abort; r.exp_rcyc = 0; r.exp_err = 1'b0; r.exp_dat = '0;
        end else begin
            slave_wins = (t.k != 0) && (t.k == resp);
            r.exp_stb  = resp;
            r.exp_rcyc = resp + 1;
            r.exp_err  = slave_wins ? t.serr : 1'b1;
            r.exp_dat  = slave_wins ? t.sdat : '0;
        end
        return r;
    endfunction

    task automatic run_txn(input txn_t t, input bit tail);
        bit done;
        r_stb = 0; r_rcyc = 0; r_err = 1'b0; r_dat = '0; r_bad = 0; r_abs = 0;
        @(negedge clk);
        m_adr = t.adr; m_dat_w = t.dat_w; m_sel = t.sel; m_we = t.we;
        m_cti = t.cti; m_bte = t.bte; m_cyc = 1'b1; m_stb = 1'b1;
        s_ack = 1'b0; s_err = 1'b0; s_dat_r = $urandom;
        done = 1'b0;
        for (int unsigned c = 1; c <= t.limit; c++) begin
            @(negedge clk);
            if (s_stb) r_stb++;
            if (s_cyc !== s_stb) r_bad++;
            if (s_adr !== t.adr || s_dat_w !== t.dat_w || s_sel !== t.sel || s_we !== t.we ||
                s_cti !== t.cti || s_bte !== t.bte) r_bad++;
            if (m_ack || m_err) begin
                if (r_rcyc == 0) begin
                    r_rcyc = c; r_err = m_err; r_dat = m_dat_r; r_abs = cyc_cnt;
                    if (m_ack && m_err) r_bad++;
                end else begin
                    r_bad++;
                end
            end else if (m_dat_r !== '0) begin
                r_bad++;
            end
            if (c == t.abort || r_rcyc != 0) begin
                m_cyc = 1'b0; m_stb = 1'b0;
            end
            s_ack   = (c == t.k) && t.sack;
            s_err   = (c == t.k) && t.serr;
            s_dat_r = (c == t.k) ? t.sdat : DW'($urandom);
            if (r_rcyc != 0 && (!tail || c > r_rcyc)) done = 1'b1;
            if (done) break;
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic verify(input txn_t t);
        check({t.name, "/stb_cycles"}, 128'(r_stb), 128'(t.exp_stb));
        check({t.name, "/rsp_cycle"}, 128'(r_rcyc), 128'(t.exp_rcyc));
        if (t.exp_rcyc != 0) begin
            check({t.name, "/err"}, 128'(r_err), 128'(t.exp_err));
            check({t.name, "/dat_r"}, 128'(r_dat), 128'(t.exp_dat));
        end
        check({t.name, "/protocol_violations"}, 128'(r_bad), 128'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        txn_t vecs[8];
        txn_t t;
        int unsigned abs_ack[3];

        vecs[0] = mk("zero_wait_read", 32'h1000, 1'b0, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'hDEADBEEF,
                     0, 30, 1, 2, 1'b0, 32'hDEADBEEF);
        vecs[1] = mk("wait_write", 32'h2004, 1'b1, 32'hA5A5A5A5, 4'hF, 5, 1'b1, 1'b0, 32'h12345678,
                     0, 30, 5, 6, 1'b0, 32'h12345678);
        vecs[2] = mk("ack_and_err", 32'h3008, 1'b0, 32'h0, 4'h3, 2, 1'b1, 1'b1, 32'hCAFEF00D,
                     0, 30, 2, 3, 1'b1, 32'hCAFEF00D);
        vecs[3] = TO_EN ?
                  mk("silent_slave", 32'h400C, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0,
                     0, 30, 8, 9, 1'b1, 32'h0) :
                  mk("silent_slave", 32'h400C, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0,
                     1000, 1003, 1000, 0, 1'b0, 32'h0);
        vecs[4] = mk("ack_in_last_cycle", 32'h5010, 1'b0, 32'h0, 4'hF, 8, 1'b1, 1'b0, 32'h0BADCAFE,
                     0, 30, 8, 9, 1'b0, 32'h0BADCAFE);
        vecs[5] = mk("err_in_last_cycle", 32'h6014, 1'b1, 32'h11223344, 4'hC, 8, 1'b0, 1'b1,
                     32'h55667788, 0, 30, 8, 9, 1'b1, 32'h55667788);
        vecs[6] = TO_EN ?
                  mk("ack_after_window", 32'h7018, 1'b0, 32'h0, 4'hF, 9, 1'b1, 1'b0, 32'h99999999,
                     0, 30, 8, 9, 1'b1, 32'h0) :
                  mk("ack_after_window", 32'h7018, 1'b0, 32'h0, 4'hF, 9, 1'b1, 1'b0, 32'h99999999,
                     0, 30, 9, 10, 1'b0, 32'h99999999);
        vecs[7] = mk("abort_cycle3", 32'h801C, 1'b1, 32'hFEEDFACE, 4'h1, 3, 1'b1, 1'b0, 32'h77777777,
                     3, 8, 3, 0, 1'b0, 32'h0);

        #3;
        check("reset_outputs_async",
              {m_ack, m_err, m_dat_r, s_cyc, s_stb, s_adr, s_dat_w, s_sel, s_we, s_cti, s_bte}, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i], 1'b1);
            verify(vecs[i]);
            @(negedge clk);
        end

        // reset asserted in the middle of REQ
        @(negedge clk);
        m_adr = 32'hABCD0000; m_dat_w = 32'h13572468; m_sel = 4'hF; m_we = 1'b1;
        m_cti = 3'd0; m_bte = 2'd0; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_req_stb_before_reset", 128'(s_stb), 128'(1));
        #2 rstn = 1'b0;
        #1 check("mid_req_reset_outputs",
                 {m_ack, m_err, m_dat_r, s_cyc, s_stb, s_adr, s_dat_w, s_sel, s_we, s_cti, s_bte}, '0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        t = vecs[0];
        t.name = "after_reset_read";
        run_txn(t, 1'b1);
        verify(t);

        // three consecutive zero-wait reads with no gap between them
        for (int unsigned i = 0; i < 3; i++) begin
            t = mk("b2b_read", 32'h9000 + 32'(4 * i), 1'b0, 32'h0, 4'hF, 1, 1'b1, 1'b0,
                   32'hB0B00000 + 32'(i), 0, 10, 1, 2, 1'b0, 32'hB0B00000 + 32'(i));
            run_txn(t, 1'b0);
            verify(t);
            abs_ack[i] = r_abs;
        end
        check("b2b_spacing_1_2", 128'(abs_ack[1] - abs_ack[0]), 128'(3));
        check("b2b_spacing_2_3", 128'(abs_ack[2] - abs_ack[1]), 128'(3));
        @(negedge clk);

        for (int unsigned n = 0; n < 60; n++) begin
            t.name  = "random";
            t.adr   = $urandom;
            t.we    = 1'($urandom);
            t.dat_w = $urandom;
            t.sel   = 4'($urandom);
            t.cti   = 3'($urandom);
            t.bte   = 2'($urandom);
            t.k     = $urandom_range(0, 12);
            t.sack  = 1'($urandom);
            t.serr  = 1'($urandom);
            t.sdat  = $urandom;
            if (!t.sack && !t.serr) t.k = 0;
            if (t.k == 0) begin
                t.sack = 1'b0; t.serr = 1'b0;
            end
            t.abort = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            if (!TO_EN && t.k == 0 && t.abort == 0) t.abort = $urandom_range(1, 12);
            t.limit = 40;
            t = model(t);
            run_txn(t, 1'b1);
            verify(t);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
